// File: rtl/cnt_sched.sv
// Round-robin scheduler sharing one up/down counter among N_REQ requesters.
// All outputs are registered; each job drives cnt_en for exactly its requested number of steps.
module cnt_sched #(
  parameter int WIDTH = 4,
  parameter int N_REQ = 4,
  parameter int LEN_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_dir,
  input  logic [N_REQ*LEN_W-1:0]   req_len,
  input  logic                     hold,
  input  logic [WIDTH-1:0]         cnt_val,
  output logic                     cnt_en,
  output logic                     dir,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic [WIDTH-1:0]         cur_val
);
  localparam int OW = $clog2(N_REQ);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nx;
  logic [N_REQ-1:0] r_gnt, w_gnt_nx;
  logic [N_REQ-1:0] r_done, w_done_nx;
  logic             r_cnt_en, w_cnt_en_nx;
  logic             r_dir, w_dir_nx;
  logic             r_busy;
  logic [OW-1:0]    r_owner, w_owner_nx;
  logic [OW-1:0]    r_last, w_last_nx;
  logic [WIDTH-1:0] r_cur_val, w_cur_val_nx;
  logic [LEN_W-1:0] r_rem, w_rem_nx;

  logic             w_pick_vld;
  logic [OW-1:0]    w_pick;
  logic [LEN_W-1:0] w_len;

  function automatic logic [OW-1:0] wrap_idx(input int i);
    return OW'((i >= N_REQ) ? (i - N_REQ) : i);
  endfunction

  // First pending request at or after last+1, wrapping around.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!w_pick_vld && req[wrap_idx(int'(r_last) + k)]) begin
        w_pick_vld = 1'b1;
        w_pick     = wrap_idx(int'(r_last) + k);
      end
    end
  end

  assign w_len = req_len[int'(w_pick)*LEN_W +: LEN_W];

  always_comb begin
    w_state_nx   = r_state;
    w_gnt_nx     = r_gnt;
    w_done_nx    = '0;
    w_cnt_en_nx  = r_cnt_en;
    w_dir_nx     = r_dir;
    w_owner_nx   = r_owner;
    w_last_nx    = r_last;
    w_cur_val_nx = r_cur_val;
    w_rem_nx     = r_rem;
    unique case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
          w_owner_nx = w_pick;
          w_dir_nx   = req_dir[w_pick];
          w_rem_nx   = w_len;
          w_gnt_nx   = N_REQ'(1) << w_pick;
          if (w_len != '0) begin
            w_cnt_en_nx = 1'b1;
            w_state_nx  = S_RUN;
          end else begin
            w_cnt_en_nx = 1'b0;
            w_done_nx   = N_REQ'(1) << w_pick;
            w_state_nx  = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (!req[r_owner]) begin
          w_cnt_en_nx = 1'b0;
          w_gnt_nx    = '0;
          w_last_nx   = r_owner;
          w_state_nx  = S_IDLE;
        end else begin
          // An enabled edge has already stepped the counter, so it always
          // consumes a step even when hold lands on it; hold gates later edges.
          if (r_cnt_en) begin
            w_rem_nx = r_rem - 1'b1;
          end
          if (r_cnt_en && (r_rem == LEN_W'(1))) begin
            w_cnt_en_nx = 1'b0;
            w_done_nx   = r_gnt;
            w_state_nx  = S_DONE;
          end else begin
            w_cnt_en_nx = !hold;
          end
        end
      end
      S_DONE: begin
        w_gnt_nx     = '0;
        w_last_nx    = r_owner;
        w_cur_val_nx = cnt_val;
        w_state_nx   = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_done    <= '0;
      r_cnt_en  <= 1'b0;
      r_dir     <= 1'b0;
      r_busy    <= 1'b0;
      r_owner   <= OW'(N_REQ - 1);
      r_last    <= OW'(N_REQ - 1);
      r_cur_val <= '0;
      r_rem     <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_gnt     <= w_gnt_nx;
      r_done    <= w_done_nx;
      r_cnt_en  <= w_cnt_en_nx;
      r_dir     <= w_dir_nx;
      r_busy    <= (w_state_nx != S_IDLE);
      r_owner   <= w_owner_nx;
      r_last    <= w_last_nx;
      r_cur_val <= w_cur_val_nx;
      r_rem     <= w_rem_nx;
    end
  end

  assign cnt_en  = r_cnt_en;
  assign dir     = r_dir;
  assign gnt     = r_gnt;
  assign done    = r_done;
  assign busy    = r_busy;
  assign owner   = r_owner;
  assign cur_val = r_cur_val;

endmodule

// File: tb/tb_cnt_sched.sv
// Bench for cnt_sched: directed scenarios plus random traffic, scored against a job-level model.
module tb_cnt_sched;
  localparam int WIDTH = 4;
  localparam int N_REQ = 4;
  localparam int LEN_W = 8;
  localparam int OW    = $clog2(N_REQ);

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       req_dir;
  logic [N_REQ*LEN_W-1:0] req_len;
  logic                   hold;
  logic [WIDTH-1:0]       cnt_val;
  logic                   cnt_en;
  logic                   dir;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [OW-1:0]          owner;
  logic [WIDTH-1:0]       cur_val;

  cnt_sched #(.WIDTH(WIDTH), .N_REQ(N_REQ), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .req(req), .req_dir(req_dir), .req_len(req_len),
    .hold(hold), .cnt_val(cnt_val), .cnt_en(cnt_en), .dir(dir), .gnt(gnt),
    .done(done), .busy(busy), .owner(owner), .cur_val(cur_val)
  );

  always #5 clk = ~clk;

  // The shared up/down counter the scheduler drives.
  always @(posedge clk) begin
    if (reset)       cnt_val <= '0;
    else if (cnt_en) cnt_val <= dir ? cnt_val + 1'b1 : cnt_val - 1'b1;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Job-level reference model.
  typedef enum {P_IDLE, P_RUN, P_DONE} phase_e;
  phase_e           ph = P_IDLE;
  int               m_last = N_REQ - 1;
  int               m_owner, m_len, m_steps;
  bit               m_dir;
  logic [WIDTH-1:0] m_start, exp_cur;
  int               grant_log[$];
  int               s_gnt, s_en, s_done;
  bit               auto_drop = 1'b1;

  function automatic int arb(input logic [N_REQ-1:0] r, input int last);
    int idx;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (last + k) % N_REQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic cyc();
    logic [N_REQ-1:0]       e_req, e_dir;
    logic [N_REQ*LEN_W-1:0] e_len;
    logic                   e_hold, e_rst, e_en;
    int                     o;
    e_req = req; e_dir = req_dir; e_len = req_len;
    e_hold = hold; e_rst = reset; e_en = cnt_en;
    @(posedge clk); #1;
    s_gnt  += (gnt != '0) ? 1 : 0;
    s_en   += cnt_en ? 1 : 0;
    s_done += (done != '0) ? 1 : 0;
    if (e_rst) begin
      check("rst_gnt", gnt, 0);     check("rst_done", done, 0);
      check("rst_en", cnt_en, 0);   check("rst_busy", busy, 0);
      check("rst_dir", dir, 0);     check("rst_owner", owner, N_REQ - 1);
      check("rst_cur", cur_val, 0);
      ph = P_IDLE; m_last = N_REQ - 1;
    end else begin
      case (ph)
        P_IDLE: begin
          if (e_req != '0) begin
            o = arb(e_req, m_last);
            m_owner = o; m_dir = e_dir[o]; m_steps = 0; m_start = cnt_val;
            m_len = int'(e_len[o*LEN_W +: LEN_W]);
            grant_log.push_back(o);
            check("grant", gnt, 1 << o); check("owner", owner, o);
            check("dir", dir, m_dir);    check("grant_busy", busy, 1);
            if (m_len == 0) begin
              check("zlen_en", cnt_en, 0); check("zlen_done", done, 1 << o);
              exp_cur = m_start; ph = P_DONE;
            end else begin
              check("start_en", cnt_en, 1); check("start_done", done, 0);
              ph = P_RUN;
            end
          end else begin
            check("idle_gnt", gnt, 0); check("idle_en", cnt_en, 0); check("idle_busy", busy, 0);
          end
        end
        P_RUN: begin
          if (e_en) m_steps++;
          if (!e_req[m_owner]) begin
            check("abort_gnt", gnt, 0);   check("abort_en", cnt_en, 0);
            check("abort_done", done, 0); check("abort_busy", busy, 0);
            m_last = m_owner; ph = P_IDLE;
          end else if (m_steps == m_len) begin
            exp_cur = m_dir ? m_start + WIDTH'(m_len) : m_start - WIDTH'(m_len);
            check("done", done, 1 << m_owner);  check("done_en", cnt_en, 0);
            check("done_gnt", gnt, 1 << m_owner); check("done_busy", busy, 1);
            check("cnt_final", cnt_val, exp_cur);
            ph = P_DONE;
          end else begin
            check("run_en", cnt_en, !e_hold); check("run_done", done, 0);
            check("run_gnt", gnt, 1 << m_owner); check("run_busy", busy, 1);
          end
        end
        default: begin
          check("post_done", done, 0); check("post_gnt", gnt, 0);
          check("post_busy", busy, 0); check("post_en", cnt_en, 0);
          check("cur_val", cur_val, exp_cur);
          m_last = m_owner; ph = P_IDLE;
        end
      endcase
    end
    if (auto_drop && ph == P_DONE) req[m_owner] = 1'b0;
  endtask

  task automatic set_job(input int i, input bit d, input int l);
    req_dir[i] = d;
    req_len[i*LEN_W +: LEN_W] = LEN_W'(l);
    req[i] = 1'b1;
  endtask

  task automatic drain(input int max);
    int k;
    k = 0;
    while ((ph != P_IDLE || req != '0) && k < max) begin
      cyc(); k++;
    end
    check("drain_bound", (ph == P_IDLE && req == '0) ? 1 : 0, 1);
  endtask

  task automatic clr_stats();
    s_gnt = 0; s_en = 0; s_done = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] a_start;
    int k;
    reset = 1'b1; req = '0; req_dir = '0; req_len = '0; hold = 1'b0;
    cyc(); cyc();
    reset = 1'b0;

    // Single job: req0 up by 5 from 0.
    clr_stats(); set_job(0, 1'b1, 5); drain(40);
    check("single_gnt_cycles", s_gnt, 6); check("single_en_cycles", s_en, 5);
    check("single_done_pulses", s_done, 1); check("single_cur", cur_val, 5);

    // Hold for 3 cycles mid-run; steps unchanged, job 3 cycles longer.
    clr_stats(); set_job(1, 1'b1, 4);
    cyc(); cyc();
    hold = 1'b1; cyc(); cyc(); cyc(); hold = 1'b0;
    drain(40);
    check("hold_job_cycles", s_gnt, 8); check("hold_en_cycles", s_en, 4);
    check("hold_cur", cur_val, 9);

    // Zero length: done straight after grant, counter untouched.
    clr_stats(); set_job(1, 1'b1, 0); drain(20);
    check("zlen_en_cycles", s_en, 0); check("zlen_done_pulses", s_done, 1);
    check("zlen_cur", cur_val, 9);

    // Wrap-around from 0.
    reset = 1'b1; cyc(); reset = 1'b0;
    set_job(0, 1'b0, 3);  drain(40); check("wrap_down_cur", cur_val, 13);
    set_job(0, 1'b1, 20); drain(60); check("wrap_up_cur", cur_val, 1);

    // Abort after 4 enabled cycles; arbitration resumes at owner+1.
    clr_stats(); set_job(2, 1'b1, 10);
    cyc(); a_start = cnt_val;
    cyc(); cyc(); cyc();
    req[2] = 1'b0; cyc();
    check("abort_steps", WIDTH'(cnt_val - a_start), 4);
    check("abort_no_done", s_done, 0);
    set_job(0, 1'b1, 1); set_job(3, 1'b1, 1);
    cyc(); check("abort_next_owner", owner, 3);
    drain(40);

    // Reset in the middle of a run.
    set_job(2, 1'b1, 10); cyc(); cyc();
    set_job(0, 1'b1, 1);
    reset = 1'b1; cyc(); reset = 1'b0;
    cyc(); check("post_rst_owner", owner, 0);
    drain(60);

    // Round-robin with every requester held continuously.
    reset = 1'b1; cyc(); reset = 1'b0;
    auto_drop = 1'b0; grant_log.delete();
    for (int i = 0; i < N_REQ; i++) set_job(i, 1'b1, 2);
    k = 0;
    while (grant_log.size() < 5 && k < 100) begin cyc(); k++; end
    check("rr_count", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) check("rr_order", grant_log[i], i % N_REQ);
    req = '0; auto_drop = 1'b1;
    drain(20);

    // Random traffic, holds, aborts and post-grant scrambling of job fields.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!req[i] && $urandom_range(7) == 0)
          set_job(i, 1'($urandom_range(1)), ($urandom_range(4) == 0) ? 0 : int'($urandom_range(1, 20)));
      end
      if (ph == P_RUN && $urandom_range(40) == 0) req[m_owner] = 1'b0;
      if (ph != P_IDLE) begin
        req_dir[m_owner] = 1'($urandom_range(1));
        req_len[m_owner*LEN_W +: LEN_W] = LEN_W'($urandom_range(255));
      end
      hold = ($urandom_range(3) == 0);
      cyc();
    end
    hold = 1'b0;
    drain(200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
